// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose : controller state encoding, the hard-wired zero register index and
//           the lower bounds on the latency parameters of pipe_ctrl.
// Ports   : none (package).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULTI = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

  localparam int REG_ZERO      = 0;
  localparam int MUL_LAT_MIN   = 2;
  localparam int FLUSH_CYC_MIN = 1;

  function automatic bit params_ok(input int mul_lat, input int flush_cyc);
    return (mul_lat >= MUL_LAT_MIN) && (flush_cyc >= FLUSH_CYC_MIN);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard comparator
//
// Purpose : flags an ID instruction that reads the register a load in EX is
//           about to write. Register 0 never hazards.
// Ports   : id_valid, id_rs1, id_rs2, id_uses_rs2  - ID stage operands
//           ex_valid, ex_rd, ex_wr, ex_is_load      - EX stage destination
//           hazard                                  - load-use hazard present
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wr,
  input  logic             ex_is_load,
  output logic             hazard
);

  logic load_live;
  logic rs1_hit;
  logic rs2_hit;

  // A load only matters if it really writes a non-zero register.
  assign load_live = ex_valid & ex_is_load & ex_wr & (ex_rd != REG_W'(REG_ZERO));
  assign rs1_hit   = (ex_rd == id_rs1);
  assign rs2_hit   = id_uses_rs2 & (ex_rd == id_rs2);
  assign hazard    = id_valid & load_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - EXE-stage hazard, multi-cycle hold and branch flush controller
//
// Purpose : detects load-use hazards, holds EX for multi-cycle ALU ops and
//           turns a taken branch into a PC redirect plus a timed flush.
//           Optional feature macro PIPE_CTRL_PERF_CNT_EN enables saturating
//           stall/flush cycle counters; without it the counter ports read 0.
// Ports   : clk, rst (async, active-low)
//           id_valid, id_rs1, id_rs2, id_uses_rs2       - ID operands
//           ex_valid, ex_rd, ex_wr, ex_is_load, ex_multi - EX instruction
//           branch_taken, jaddr_in                      - EXE branch unit
//           stall_if, stall_id, flush_id, flush_ex, alu_hold - pipeline control
//           pc_load, pc_target                          - PC redirect
//           busy                                        - controller not in RUN
//           stall_cnt, flush_cnt                        - performance counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W     = 4,
  parameter int JADDR_W   = 13,
  parameter int MUL_LAT   = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_rs1,
  input  logic [REG_W-1:0]   id_rs2,
  input  logic               id_uses_rs2,
  input  logic               ex_valid,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               ex_wr,
  input  logic               ex_is_load,
  input  logic               ex_multi,
  input  logic               branch_taken,
  input  logic [JADDR_W-1:0] jaddr_in,
  output logic               stall_if,
  output logic               stall_id,
  output logic               flush_id,
  output logic               flush_ex,
  output logic               alu_hold,
  output logic               pc_load,
  output logic [JADDR_W-1:0] pc_target,
  output logic               busy,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
);

  localparam int CNT_MAX = (MUL_LAT > FLUSH_CYC) ? MUL_LAT : FLUSH_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_INIT   = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'((FLUSH_CYC > 1) ? (FLUSH_CYC - 2) : 0);
  // A one-cycle flush is fully covered by the detection cycle, so no FLUSH state.
  localparam bit USE_FLUSH = (FLUSH_CYC > 1);

  generate
    if (!params_ok(MUL_LAT, FLUSH_CYC)) begin : g_bad_params
      $error("pipe_ctrl: MUL_LAT must be >= 2 and FLUSH_CYC must be >= 1");
    end
  endgenerate

  ctrl_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             hazard;

  assign cnt_zero = (cnt == '0);

  pipe_ctrl_hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard (
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_uses_rs2(id_uses_rs2),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_wr      (ex_wr),
    .ex_is_load (ex_is_load),
    .hazard     (hazard)
  );

  // Outputs are gated by rst so an asserted reset silences them at once,
  // even before the asynchronous state clear has propagated.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    alu_hold  = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    if (rst) begin
      case (state)
        RUN: begin
          // Priority: branch > multi-cycle op > load-use.
          if (branch_taken) begin
            pc_load   = 1'b1;
            pc_target = jaddr_in;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
          end else if (ex_valid && ex_multi) begin
            alu_hold = 1'b1;
            stall_if = 1'b1;
            stall_id = 1'b1;
          end else if (hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        MULTI: begin
          // The cnt==0 cycle releases EX so the op leaves on this edge.
          if (!cnt_zero) begin
            alu_hold = 1'b1;
            stall_if = 1'b1;
            stall_id = 1'b1;
          end
        end
        FLUSH: begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if (USE_FLUSH) begin
              state <= FLUSH;
              cnt   <= FLUSH_INIT;
            end
          end else if (ex_valid && ex_multi) begin
            state <= MULTI;
            cnt   <= MUL_INIT;
          end
        end
        MULTI, FLUSH: begin
          if (cnt_zero) begin
            state <= RUN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The branch unit must not fire while a multi-cycle op owns EX.
  a_no_branch_in_multi: assert property (
    @(posedge clk) disable iff (!rst) (state == MULTI) |-> !branch_taken
  );

`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (flush_id && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int REG_W     = 4;
  localparam int JADDR_W   = 13;
  localparam int MUL_LAT   = 4;
  localparam int FLUSH_CYC = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               id_valid;
  logic [REG_W-1:0]   id_rs1;
  logic [REG_W-1:0]   id_rs2;
  logic               id_uses_rs2;
  logic               ex_valid;
  logic [REG_W-1:0]   ex_rd;
  logic               ex_wr;
  logic               ex_is_load;
  logic               ex_multi;
  logic               branch_taken;
  logic [JADDR_W-1:0] jaddr_in;
  logic               stall_if;
  logic               stall_id;
  logic               flush_id;
  logic               flush_ex;
  logic               alu_hold;
  logic               pc_load;
  logic [JADDR_W-1:0] pc_target;
  logic               busy;
  logic [15:0]        stall_cnt;
  logic [15:0]        flush_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .REG_W(REG_W), .JADDR_W(JADDR_W), .MUL_LAT(MUL_LAT), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .ex_multi(ex_multi), .branch_taken(branch_taken), .jaddr_in(jaddr_in),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .alu_hold(alu_hold), .pc_load(pc_load), .pc_target(pc_target), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic               stall_if;
    logic               stall_id;
    logic               flush_id;
    logic               flush_ex;
    logic               alu_hold;
    logic               pc_load;
    logic [JADDR_W-1:0] pc_target;
    logic               busy;
    logic [15:0]        stall_cnt;
    logic [15:0]        flush_cnt;
  } obs_t;

  typedef struct packed {
    obs_t obs;
    logic in_multi;
  } slot_t;

  typedef struct {
    logic               rst;
    logic               id_valid;
    logic [REG_W-1:0]   id_rs1;
    logic [REG_W-1:0]   id_rs2;
    logic               id_uses_rs2;
    logic               ex_valid;
    logic [REG_W-1:0]   ex_rd;
    logic               ex_wr;
    logic               ex_is_load;
    logic               ex_multi;
    logic               branch_taken;
    logic [JADDR_W-1:0] jaddr;
  } stim_t;

  // Reference: a committed sequence of future output cycles, plus a counter
  // of stall/flush cycles seen so far.
  slot_t pend_q[$];
  obs_t  exp_q[$];
  int    stall_n = 0;
  int    flush_n = 0;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  task automatic model_step(input stim_t s, output obs_t e);
    slot_t sl;
    bit    hz;
    e = '0;
    if (!s.rst) begin
      pend_q.delete();
      stall_n = 0;
      flush_n = 0;
      return;
    end
    if (pend_q.size() > 0) begin
      sl = pend_q.pop_front();
      e  = sl.obs;
    end else if (s.branch_taken) begin
      e.pc_load   = 1'b1;
      e.pc_target = s.jaddr;
      e.flush_id  = 1'b1;
      e.flush_ex  = 1'b1;
      for (int i = 0; i < FLUSH_CYC - 1; i++) begin
        sl = '0;
        sl.obs.flush_id = 1'b1;
        sl.obs.flush_ex = 1'b1;
        sl.obs.busy     = 1'b1;
        pend_q.push_back(sl);
      end
    end else if (s.ex_valid && s.ex_multi) begin
      e.alu_hold = 1'b1;
      e.stall_if = 1'b1;
      e.stall_id = 1'b1;
      for (int i = 0; i < MUL_LAT - 2; i++) begin
        sl = '0;
        sl.obs.alu_hold = 1'b1;
        sl.obs.stall_if = 1'b1;
        sl.obs.stall_id = 1'b1;
        sl.obs.busy     = 1'b1;
        sl.in_multi     = 1'b1;
        pend_q.push_back(sl);
      end
      sl = '0;
      sl.obs.busy = 1'b1;
      sl.in_multi = 1'b1;
      pend_q.push_back(sl);
    end else begin
      hz = s.id_valid && s.ex_valid && s.ex_is_load && s.ex_wr && (s.ex_rd != 0) &&
           ((s.ex_rd == s.id_rs1) || (s.id_uses_rs2 && (s.ex_rd == s.id_rs2)));
      if (hz) begin
        e.stall_if = 1'b1;
        e.stall_id = 1'b1;
        e.flush_ex = 1'b1;
      end
    end
`ifdef PIPE_CTRL_PERF_CNT_EN
    e.stall_cnt = (stall_n >= 65535) ? 16'hFFFF : 16'(stall_n);
    e.flush_cnt = (flush_n >= 65535) ? 16'hFFFF : 16'(flush_n);
    if (e.stall_if && stall_n < 65535) stall_n++;
    if (e.flush_id && flush_n < 65535) flush_n++;
`endif
  endtask

  task automatic drive(input stim_t s);
    obs_t e;
    @(posedge clk);
    #1;
    rst          = s.rst;
    id_valid     = s.id_valid;
    id_rs1       = s.id_rs1;
    id_rs2       = s.id_rs2;
    id_uses_rs2  = s.id_uses_rs2;
    ex_valid     = s.ex_valid;
    ex_rd        = s.ex_rd;
    ex_wr        = s.ex_wr;
    ex_is_load   = s.ex_is_load;
    ex_multi     = s.ex_multi;
    branch_taken = s.branch_taken;
    jaddr_in     = s.jaddr;
    model_step(s, e);
    exp_q.push_back(e);
  endtask

  // Reset asserted for part of one cycle only, released before the next edge.
  task automatic reset_pulse();
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    drive(s);
    #6;
    rst = 1'b1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1;
    s.id_valid = 1'b0; s.id_rs1 = '0; s.id_rs2 = '0; s.id_uses_rs2 = 1'b0;
    s.ex_valid = 1'b0; s.ex_rd = '0; s.ex_wr = 1'b0; s.ex_is_load = 1'b0;
    s.ex_multi = 1'b0; s.branch_taken = 1'b0; s.jaddr = '0;
    return s;
  endfunction

  function automatic stim_t load_use();
    stim_t s;
    s = idle();
    s.ex_valid = 1'b1; s.ex_is_load = 1'b1; s.ex_wr = 1'b1; s.ex_rd = 4'd3;
    s.id_valid = 1'b1; s.id_rs1 = 4'd3; s.id_rs2 = 4'd2; s.id_uses_rs2 = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim(input bit allow_branch);
    stim_t s;
    s.rst          = 1'b1;
    s.id_valid     = ($urandom_range(0, 3) != 0);
    s.id_rs1       = REG_W'($urandom_range(0, 3));
    s.id_rs2       = REG_W'($urandom_range(0, 3));
    s.id_uses_rs2  = 1'($urandom_range(0, 1));
    s.ex_valid     = ($urandom_range(0, 3) != 0);
    s.ex_rd        = REG_W'($urandom_range(0, 3));
    s.ex_wr        = ($urandom_range(0, 3) != 0);
    s.ex_is_load   = 1'($urandom_range(0, 1));
    s.ex_multi     = ($urandom_range(0, 7) == 0);
    s.branch_taken = allow_branch && ($urandom_range(0, 9) == 0);
    s.jaddr        = JADDR_W'($urandom);
    return s;
  endfunction

  always @(negedge clk) begin : monitor
    obs_t a;
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.stall_if  = stall_if;
      a.stall_id  = stall_id;
      a.flush_id  = flush_id;
      a.flush_ex  = flush_ex;
      a.alu_hold  = alu_hold;
      a.pc_load   = pc_load;
      a.pc_target = pc_target;
      a.busy      = busy;
      a.stall_cnt = stall_cnt;
      a.flush_cnt = flush_cnt;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL out cyc=%0d act si=%b sd=%b fi=%b fe=%b ah=%b pl=%b pt=%h bz=%b sc=%0d fc=%0d exp si=%b sd=%b fi=%b fe=%b ah=%b pl=%b pt=%h bz=%b sc=%0d fc=%0d",
                 cyc, a.stall_if, a.stall_id, a.flush_id, a.flush_ex, a.alu_hold, a.pc_load,
                 a.pc_target, a.busy, a.stall_cnt, a.flush_cnt,
                 e.stall_if, e.stall_id, e.flush_id, e.flush_ex, e.alu_hold, e.pc_load,
                 e.pc_target, e.busy, e.stall_cnt, e.flush_cnt);
      end
    end
    cyc++;
  end

  initial begin : stimulus
    stim_t s;
    bit    allow;
    rst = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
    ex_valid = 1'b0; ex_rd = '0; ex_wr = 1'b0; ex_is_load = 1'b0;
    ex_multi = 1'b0; branch_taken = 1'b0; jaddr_in = '0;

    s = idle();
    s.rst = 1'b0;
    repeat (3) drive(s);
    drive(idle());

    // Load-use on rs1, then the same with r0 as destination.
    drive(load_use());
    drive(idle());
    s = load_use();
    s.ex_rd = '0; s.id_rs1 = '0;
    drive(s);
    drive(idle());

    // Taken branch; held high into the flush cycle where it is ignored.
    s = idle();
    s.branch_taken = 1'b1; s.jaddr = 13'h0A5;
    drive(s);
    drive(s);
    drive(idle());
    drive(idle());

    // Multi-cycle op held for its full occupancy.
    s = idle();
    s.ex_valid = 1'b1; s.ex_multi = 1'b1;
    repeat (MUL_LAT) drive(s);
    drive(idle());

    // Branch wins over a simultaneous load-use hazard.
    s = load_use();
    s.branch_taken = 1'b1; s.jaddr = 13'h1234;
    drive(s);
    drive(idle());
    drive(idle());

    // Async reset part-way through MULTI.
    s = idle();
    s.ex_valid = 1'b1; s.ex_multi = 1'b1;
    drive(s);
    drive(s);
    reset_pulse();
    drive(idle());
    drive(idle());

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_pulse();
      end else begin
        allow = !(pend_q.size() > 0 && pend_q[0].in_multi);
        drive(rand_stim(allow));
      end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    reset_pulse();
    drive(load_use());
    drive(idle());
    drive(load_use());
    s = idle();
    s.branch_taken = 1'b1; s.jaddr = 13'h0A5;
    drive(s);
    drive(idle());
    drive(idle());
    repeat (70000) drive(load_use());
    drive(idle());
`endif

    drive(idle());
    drive(idle());
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain act=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
